// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types, digit encoding and sizing helpers for the Booth multiplier
package booth_pkg;

    // Control FSM of the iterative partial-product accumulator.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit positions of one digit's control code {neg, two, one} = {o_2, o_1, o_0}.
    localparam int DIG_NEG_BIT = 2;
    localparam int DIG_TWO_BIT = 1;
    localparam int DIG_ONE_BIT = 0;

    // Digit codes. NEG_ZERO is legal and contributes 0; any code with
    // both TWO and ONE set is illegal and also contributes 0.
    typedef enum logic [2:0] {
        DIG_ZERO     = 3'b000,
        DIG_POS_A    = 3'b001,
        DIG_POS_2A   = 3'b010,
        DIG_NEG_ZERO = 3'b100,
        DIG_NEG_A    = 3'b101,
        DIG_NEG_2A   = 3'b110
    } digit_code_t;

    // Number of radix-4 digits for an operand width.
    function automatic int ndig(input int bit_width);
        return bit_width / 2;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// rtl/booth_pp_gen.sv - combinational radix-4 Booth digit to partial-product selector
//
// Ports:
//   a        signed multiplicand
//   neg      digit negate bit (o_2)
//   two      digit select-2A bit (o_1)
//   one      digit select-A bit (o_0)
//   pp       signed partial product, bit_width+2 wide
//   illegal  digit had both two and one set (pp forced to 0)
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int bit_width = 16
) (
    input  logic [bit_width-1:0] a,
    input  logic                 neg,
    input  logic                 two,
    input  logic                 one,
    output logic [bit_width+1:0] pp,
    output logic                 illegal
);

    logic [2:0]           code;
    logic [bit_width+1:0] mag;

    always_comb begin
        code              = '0;
        code[DIG_NEG_BIT] = neg;
        code[DIG_TWO_BIT] = two;
        code[DIG_ONE_BIT] = one;

        mag     = '0;
        illegal = 1'b0;
        case ({code[DIG_TWO_BIT], code[DIG_ONE_BIT]})
            2'b01:   mag = {{2{a[bit_width-1]}}, a};
            2'b10:   mag = {a[bit_width-1], a, 1'b0};
            2'b11:   illegal = 1'b1;
            default: mag = '0;
        endcase

        // Negating a zero magnitude yields zero, so NEG_ZERO and illegal
        // codes contribute exactly 0 without a special case.
        pp = code[DIG_NEG_BIT] ? (~mag + 1'b1) : mag;
    end

endmodule

// File: rtl/booth_pp_accumulator.sv
// rtl/booth_pp_accumulator.sv - iterative radix-4 Booth partial-product accumulator
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid, in_ready  operation handshake (a + per-digit neg/two/one)
//   a                   signed multiplicand
//   neg, two, one       per-digit Booth controls (o_2, o_1, o_0)
//   out_valid, out_ready product handshake
//   product             signed 2*bit_width product, stable while out_valid
//   err                 sticky illegal-digit flag, cleared only by rst
module booth_pp_accumulator
    import booth_pkg::*;
#(
    parameter int bit_width = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [bit_width-1:0]             a,
    input  logic [ndig(bit_width)-1:0]       neg,
    input  logic [ndig(bit_width)-1:0]       two,
    input  logic [ndig(bit_width)-1:0]       one,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [2*bit_width-1:0]           product,
    output logic                             err
);

    localparam int NDIG = ndig(bit_width);
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PW   = 2 * bit_width;

    state_t               state, state_n;
    logic [CW-1:0]        cnt;
    logic [bit_width-1:0] a_q;
    logic [NDIG-1:0]      neg_q, two_q, one_q;
    logic [PW-1:0]        acc;
    logic                 err_q;

    logic [bit_width+1:0] pp;
    logic                 illegal;
    logic [PW-1:0]        pp_ext;
    logic [PW-1:0]        pp_shifted;
    logic                 last_digit;

    assign last_digit = (cnt == CW'(NDIG - 1));

    booth_pp_gen #(
        .bit_width(bit_width)
    ) u_pp_gen (
        .a       (a_q),
        .neg     (neg_q[cnt]),
        .two     (two_q[cnt]),
        .one     (one_q[cnt]),
        .pp      (pp),
        .illegal (illegal)
    );

    // Digit cnt has weight 4^cnt: sign-extend then shift by 2*cnt.
    assign pp_ext     = {{(PW - bit_width - 2){pp[bit_width+1]}}, pp};
    assign pp_shifted = pp_ext << {cnt, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = RUN;
            end
            RUN: begin
                if (last_digit) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            a_q   <= '0;
            neg_q <= '0;
            two_q <= '0;
            one_q <= '0;
            acc   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        neg_q <= neg;
                        two_q <= two;
                        one_q <= one;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc + pp_shifted;
                    err_q <= err_q | illegal;
                    cnt   <= last_digit ? '0 : cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign product = acc;
    assign err     = err_q;

endmodule

// File: doc/booth_pp_accumulator.md
# booth_pp_accumulator

Iterative radix-4 Booth multiplier back end. Consumes the per-digit Booth control bits from the Booth encoder together with the signed multiplicand. Each clock, it generates one partial product and accumulates it into a full-width signed product. Sits directly downstream of the encoder in the mul path and hands the finished product to the consumer through a valid/ready handshake.

## Interface
- `bit_width`, default 16: operand width, even, ≥4; the digit count is `NDIG = bit_width/2`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands and Booth digits are valid.
- `in_ready`  out  1  block can accept a new operation.
- `a`  in  `bit_width`  signed two's-complement multiplicand.
- `neg`  in  `NDIG`  per-digit negate bit; this is encoder output `o_2`.
- `two`  in  `NDIG`  per-digit select-2A bit; this is encoder output `o_1`.
- `one`  in  `NDIG`  per-digit select-A bit; this is encoder output `o_0`.
- `out_valid`  out  1  `product` is valid.
- `out_ready`  in  1  consumer accepts `product`.
- `product`  out  `2*bit_width`  signed product `a*b`.
- `err`  out  1  sticky flag: an illegal digit code was seen.

## Operation
- Digit i has weight 4^i. Its value is {0, ±A, ±2A} and is decoded as follows:
  - `one` selects A, `two` selects 2A, neither selects 0.
  - `neg` negates the selected value.
  - `neg` with neither select bit set contributes exactly 0.
- `one & two` both set is illegal for a digit:
  - That digit contributes 0.
  - `err` is set at the edge the digit is processed.
  - `err` is cleared only by `rst`.
- Partial-product width is `bit_width+2` signed: A is sign-extended, 2A is A shifted left by 1, and negation is two's complement at that width.
- Each partial product is sign-extended to `2*bit_width`, shifted left by 2i and added to the accumulator modulo 2^(2*bit_width). This is exact because a signed N×N product fits in 2N bits.
- On accept (`in_valid && in_ready`):
  - `a`, `neg`, `two` and `one` are registered. Inputs are ignored at all other times.
  - The accumulator is cleared and the digit counter is set to 0.
- FSM states and transitions:
  - IDLE: `in_ready`=1. Moves to RUN on accept.
  - RUN: processes digit `cnt` and increments `cnt`. After digit NDIG-1 is processed, moves to DONE.
  - DONE: `out_valid`=1 and `product` is held stable. Moves to IDLE on `out_ready`.
- All NDIG digits are always processed; there is no early termination on zero digits.

## Timing
- Reset values:
  - state IDLE, `in_ready`=1, `out_valid`=0, `product`=0, `err`=0.
  - Counter and accumulator are 0.
- Latency: if the accept occurs at edge k, `out_valid` rises after edge k+NDIG. For `bit_width`=16 that is 8 cycles.
- `in_ready` is 0 in RUN and DONE. There is no input/output overlap, so throughput is one operation per NDIG+2 cycles when `out_ready` is held high.
- Backpressure: in DONE with `out_ready`=0, `product` and `out_valid` hold indefinitely.
- DONE with `out_ready`=1 moves to IDLE at that edge. `in_ready` is 1 from the following cycle; there is no same-cycle bypass.
- `rst` asserted in any state, including mid-RUN, returns everything to the reset values at that edge. The in-flight result is discarded.
- The counter wraps only through the RUN→DONE transition and never indexes past NDIG-1.

## Structure
- Shared package `booth_pkg` holds:
  - state enum {IDLE, RUN, DONE};
  - the digit-value encoding and bit positions (neg=o_2, two=o_1, one=o_0);
  - the `NDIG` function of `bit_width`.
- Sub-module `booth_pp_gen` is the combinational digit-to-partial-product selector. Its inputs are `a`, `neg`, `two` and `one` for one digit; its outputs are a `bit_width+2` signed partial product and an illegal flag. The top block holds the FSM, the registers and the accumulator.

## Test plan
All scenarios use `bit_width`=16. Digit bits are driven from a golden encoder model of the multiplier b, with b₋₁=0.
- a=3, b=5, `out_ready`=1 → `out_valid` rises 8 cycles after accept, `product`=15, `err`=0, `in_ready` returns the cycle after the handshake.
- Corner products:
  - a=-32768, b=-32768 → `product`=0x40000000.
  - a=32767, b=-32768 → `product`=-1073709056.
  - a=0 with b=-1 → `product`=0.
- Illegal digit: `one`=`two`=1 on digit 3 with a=7 and all other digits 0 → `product`=0 and `err`=1. `err` stays 1 across the next operation until `rst`.
- Backpressure: `out_ready`=0 for 20 cycles in DONE → `product` is stable, `in_ready`=0 and `in_valid` pulses are ignored. Raising `out_ready` completes the handshake.
- Reset at the 4th RUN cycle → the next cycle shows IDLE with every output at its reset value. A new operation (a=-2, b=9) then gives `product`=-18.
- 1000 random back-to-back operations with random `out_ready` → every product matches a*b and `err` stays 0.
